// File: rtl/flash_pkg.sv
// Types and widths shared by flash_driver, flash_test and the boot loader.
package flash_pkg;

    localparam int FL_AW = 22;
    localparam int FL_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/flash_boot_loader_if.sv
// Flash-driver side and RAM write-port side of the boot loader.
interface flash_boot_loader_if #(
    parameter int FL_AW  = flash_pkg::FL_AW,
    parameter int RAM_AW = 18,
    parameter int DW     = flash_pkg::FL_DW
);
    logic [FL_AW-1:0]  fl_addr;
    logic              fl_enable_read;
    logic              fl_busy;
    logic [DW-1:0]     fl_data;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic              ram_we;
    logic              ram_ready;

    modport master (
        output fl_addr, fl_enable_read, ram_addr, ram_wdata, ram_we,
        input  fl_busy, fl_data, ram_ready
    );

    modport slave (
        input  fl_addr, fl_enable_read, ram_addr, ram_wdata, ram_we,
        output fl_busy, fl_data, ram_ready
    );
endinterface

// File: rtl/fl_read_handshake.sv
// One flash word read: wait for an idle driver, pulse enable_read, follow busy
// high then low, and hand back the data word or a timeout.
module fl_read_handshake #(
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    output logic          ack_o,
    output logic [DW-1:0] data_o,
    output logic          timeout_o,
    output logic [AW-1:0] fl_addr_o,
    output logic          fl_enable_read_o,
    input  logic          fl_busy_i,
    input  logic [DW-1:0] fl_data_i
);
    import flash_pkg::*;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;

    assign fl_addr_o = addr_q;
    assign data_o    = fl_data_i;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        fl_enable_read_o = 1'b0;
        ack_o            = 1'b0;
        timeout_o        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!fl_busy_i) begin
                    fl_enable_read_o = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // cnt_q counts completed WAIT_HI cycles; the last allowed one gives up
                if (fl_busy_i) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_o = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!fl_busy_i) begin
                    ack_o   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/flash_boot_loader.sv
// Copies word_count flash words into RAM and keeps a running 16-bit checksum.
// Reads are delegated to fl_read_handshake; this level owns index, RAM port and sum.
module flash_boot_loader #(
    parameter int FL_AW   = flash_pkg::FL_AW,
    parameter int RAM_AW  = 18,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [FL_AW-1:0]    src_addr_i,
    input  logic [RAM_AW-1:0]   dst_addr_i,
    input  logic [FL_AW-1:0]    word_count_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [15:0]         checksum_o,
    flash_boot_loader_if.master bus
);
    import flash_pkg::*;

    localparam int DW = FL_DW;

    // S_ISSUE here covers the whole read; the handshake tracks its finer states
    state_t            state_q, state_d;
    logic [FL_AW-1:0]  idx_q, idx_d;
    logic [FL_AW-1:0]  src_q, src_d;
    logic [RAM_AW-1:0] dst_q, dst_d;
    logic [FL_AW-1:0]  count_q, count_d;
    logic [15:0]       checksum_q, checksum_d;
    logic              error_q, error_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0]     ram_wdata_q, ram_wdata_d;

    logic              rd_req;
    logic [FL_AW-1:0]  rd_addr;
    logic              rd_ack;
    logic              rd_timeout;
    logic [DW-1:0]     rd_data;

    fl_read_handshake #(
        .AW      (FL_AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) u_rd (
        .clk              (clk),
        .rst              (rst),
        .req_i            (rd_req),
        .addr_i           (rd_addr),
        .ack_o            (rd_ack),
        .data_o           (rd_data),
        .timeout_o        (rd_timeout),
        .fl_addr_o        (bus.fl_addr),
        .fl_enable_read_o (bus.fl_enable_read),
        .fl_busy_i        (bus.fl_busy),
        .fl_data_i        (bus.fl_data)
    );

    assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WRITE);
    assign done_o        = (state_q == S_DONE);
    assign error_o       = error_q;
    assign checksum_o    = checksum_q;
    assign bus.ram_we    = (state_q == S_WRITE);
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        src_d       = src_q;
        dst_d       = dst_q;
        count_d     = count_q;
        checksum_d  = checksum_q;
        error_d     = error_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd_req      = 1'b0;
        rd_addr     = src_q + idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d      = src_addr_i;
                    dst_d      = dst_addr_i;
                    count_d    = word_count_i;
                    idx_d      = '0;
                    checksum_d = '0;
                    error_d    = 1'b0;
                    if (word_count_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // first read starts from the live inputs, the latches land this edge
                        rd_req  = 1'b1;
                        rd_addr = src_addr_i;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (rd_timeout) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if (rd_ack) begin
                    ram_wdata_d = rd_data;
                    ram_addr_d  = dst_q + RAM_AW'(idx_q);
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.ram_ready) begin
                    checksum_d = checksum_q + ram_wdata_q;
                    idx_d      = idx_q + 1'b1;
                    if (idx_d == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        rd_req  = 1'b1;
                        rd_addr = src_q + idx_d;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            checksum_q  <= '0;
            error_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            checksum_q  <= checksum_d;
            error_q     <= error_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        src_q   <= src_d;
        dst_q   <= dst_d;
        count_q <= count_d;
    end
endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader with a 3-busy-cycle flash model and a stalling RAM.
module tb_flash_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [21:0] src_addr = '0;
    logic [17:0] dst_addr = '0;
    logic [21:0] word_count = '0;
    logic        busy, done, error;
    logic [15:0] checksum;

    int n_checks = 0;
    int n_errors = 0;

    flash_boot_loader_if bus ();

    flash_boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .word_count_i (word_count),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .checksum_o   (checksum),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // flash_driver model: 3 busy cycles per read, word = address ^ A5A5
    int          fl_cnt = 0;
    logic [21:0] fl_lat = '0;
    bit          fl_dead = 1'b0;
    bit          bp_en = 1'b0;
    int          stall = 0;

    assign bus.fl_busy   = (fl_cnt != 0);
    assign bus.fl_data   = fl_lat[15:0] ^ 16'hA5A5;
    assign bus.ram_ready = !bp_en || (stall >= 5);

    always @(posedge clk) begin
        if (bus.fl_enable_read && !fl_dead) begin
            fl_cnt <= 3;
            fl_lat <= bus.fl_addr;
        end else if (fl_cnt != 0) begin
            fl_cnt <= fl_cnt - 1;
        end
        if (bus.ram_we && bus.ram_ready) stall <= 0;
        else if (bus.ram_we)             stall <= stall + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [21:0] en_log[$];
    logic [17:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic        prev_en = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_acc = 1'b0;
    logic [33:0] prev_aw = '0;

    always @(negedge clk) begin
        if (bus.fl_enable_read) begin
            en_log.push_back(bus.fl_addr);
            chk("en_not_back_to_back", prev_en, 1'b0);
            chk("en_while_we", bus.ram_we, 1'b0);
        end
        if (bus.ram_we && prev_we && !prev_acc)
            chk("ram_hold_during_stall", {bus.ram_addr, bus.ram_wdata}, prev_aw);
        if (bus.ram_we && bus.ram_ready) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_wdata);
        end
        prev_en  <= bus.fl_enable_read;
        prev_we  <= bus.ram_we;
        prev_acc <= bus.ram_we && bus.ram_ready;
        prev_aw  <= {bus.ram_addr, bus.ram_wdata};
    end

    task automatic copy(input logic [21:0] src, input logic [17:0] dst, input logic [21:0] cnt);
        en_log.delete();
        wr_addr.delete();
        wr_data.delete();
        src_addr   = src;
        dst_addr   = dst;
        word_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1'b1);
        chk("busy_low_at_done", busy, 1'b0);
    endtask

    task automatic verify(input string tag, input logic [21:0] src, input logic [17:0] dst, input int cnt);
        logic [15:0] sum;
        logic [21:0] a;
        logic [17:0] r;
        sum = '0;
        chk({tag, "_reads"}, en_log.size(), cnt);
        chk({tag, "_writes"}, wr_addr.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            a = src + 22'(i);
            r = dst + 18'(i);
            sum = sum + (a[15:0] ^ 16'hA5A5);
            chk({tag, "_fl_addr"}, (i < en_log.size()) ? en_log[i] : 22'hx, a);
            chk({tag, "_ram_addr"}, (i < wr_addr.size()) ? wr_addr[i] : 18'hx, r);
            chk({tag, "_ram_data"}, (i < wr_data.size()) ? wr_data[i] : 16'hx, a[15:0] ^ 16'hA5A5);
        end
        chk({tag, "_checksum"}, checksum, sum);
    endtask

    int n;
    int nw;
    int nr;

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_checksum", checksum, 16'h0);
        chk("rst_fl_addr", bus.fl_addr, 22'h0);
        chk("rst_fl_en", bus.fl_enable_read, 1'b0);
        chk("rst_ram_we", bus.ram_we, 1'b0);
        chk("rst_ram_addr", bus.ram_addr, 18'h0);
        chk("rst_ram_wdata", bus.ram_wdata, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // basic copy
        copy(22'h100, 18'h20, 22'd4);
        chk("basic_start_busy", busy, 1'b1);
        chk("basic_start_en", bus.fl_enable_read, 1'b1);
        chk("basic_start_fl_addr", bus.fl_addr, 22'h100);
        wait_done(200, n);
        chk("basic_checksum_const", checksum, 16'h9296);
        chk("basic_error", error, 1'b0);
        verify("basic", 22'h100, 18'h20, 4);
        @(negedge clk);
        chk("basic_done_one_pulse", done, 1'b0);

        // zero count
        copy(22'h100, 18'h20, 22'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        @(negedge clk);
        chk("zero_done_one_pulse", done, 1'b0);
        chk("zero_reads", en_log.size(), 0);
        chk("zero_writes", wr_addr.size(), 0);
        chk("zero_checksum", checksum, 16'h0);

        // RAM backpressure
        bp_en = 1'b1;
        copy(22'h100, 18'h20, 22'd4);
        wait_done(400, n);
        chk("bp_checksum_const", checksum, 16'h9296);
        verify("bp", 22'h100, 18'h20, 4);
        bp_en = 1'b0;
        @(negedge clk);

        // address wrap-around
        copy(22'h3FFFFF, 18'h3FFFF, 22'd2);
        wait_done(200, n);
        chk("wrap_checksum_const", checksum, 16'hFFFF);
        verify("wrap", 22'h3FFFFF, 18'h3FFFF, 2);
        @(negedge clk);

        // timeout: flash never goes busy
        fl_dead = 1'b1;
        copy(22'h10, 18'h0, 22'd1);
        chk("to_issue_en", bus.fl_enable_read, 1'b1);
        wait_done(400, n);
        chk("to_latency", n, 256);
        chk("to_error", error, 1'b1);
        chk("to_writes", wr_addr.size(), 0);
        @(negedge clk);
        chk("to_error_sticky", error, 1'b1);
        fl_dead = 1'b0;
        copy(22'h10, 18'h5, 22'd1);
        chk("to_error_cleared", error, 1'b0);
        wait_done(200, n);
        verify("after_to", 22'h10, 18'h5, 1);
        @(negedge clk);

        // reset during WAIT_LO of word 2
        copy(22'h200, 18'h80, 22'd4);
        n = 0;
        while (!(en_log.size() == 2 && fl_cnt == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_wait_lo", n < 200, 1'b1);
        chk("mid_checksum_nonzero", checksum != 16'h0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_error", error, 1'b0);
        chk("mid_rst_checksum", checksum, 16'h0);
        chk("mid_rst_fl_addr", bus.fl_addr, 22'h0);
        chk("mid_rst_fl_en", bus.fl_enable_read, 1'b0);
        chk("mid_rst_ram_we", bus.ram_we, 1'b0);
        chk("mid_rst_ram_addr", bus.ram_addr, 18'h0);
        chk("mid_rst_ram_wdata", bus.ram_wdata, 16'h0);
        rst = 1'b0;
        nr = en_log.size();
        nw = wr_addr.size();
        repeat (20) @(negedge clk);
        chk("mid_no_reads_after", en_log.size(), nr);
        chk("mid_no_writes_after", wr_addr.size(), nw);
        copy(22'h100, 18'h20, 22'd4);
        wait_done(200, n);
        chk("mid_recopy_checksum_const", checksum, 16'h9296);
        verify("mid_recopy", 22'h100, 18'h20, 4);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
